veggie_banked_rf: RTL and testbench

Parametrised, multi-bank vector register file ("veggie" successor) feeding the VALU and scoreboard.
- Generalises the single-port veggie to NUM_RPORTS read ports, NUM_BANKS banks and per-element masked writes.
- Adds bank-conflict arbitration with round-robin fairness, write-to-read bypass, and a multi-cycle bulk-clear mode.
- Sits between the scoreboard/dispatch (read requests) and the VALU/scratchpad writeback path.

---
 rtl/veggie_banked_rf_if.sv | 33 +++
 rtl/veggie_banked_rf.sv | 120 ++++++++++++
 tb/tb_veggie_banked_rf.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/veggie_banked_rf_if.sv
// veggie_banked_rf_if: read ports, write port and bulk-clear handshake of the
// banked vector register file.
interface veggie_banked_rf_if #(
    parameter int NUM_REGS     = 32,
    parameter int NUM_ELEMENTS = 16,
    parameter int ELEM_W       = 16,
    parameter int NUM_RPORTS   = 2
);
    localparam int SW = $clog2(NUM_REGS);

    logic [NUM_RPORTS-1:0]                                rd_valid;
    logic [NUM_RPORTS-1:0][SW-1:0]                        rd_sel;
    logic [NUM_RPORTS-1:0]                                rd_ready;
    logic [NUM_RPORTS-1:0]                                rd_data_valid;
    logic [NUM_RPORTS-1:0][NUM_ELEMENTS-1:0][ELEM_W-1:0] rd_data;
    logic                                                 wen;
    logic [SW-1:0]                                        wsel;
    logic [NUM_ELEMENTS-1:0][ELEM_W-1:0]                  wdata;
    logic [NUM_ELEMENTS-1:0]                              wmask;
    logic                                                 clear_req;
    logic                                                 busy;
    logic                                                 clear_done;
    logic                                                 werr;

    modport master (
        output rd_valid, rd_sel, wen, wsel, wdata, wmask, clear_req,
        input  rd_ready, rd_data_valid, rd_data, busy, clear_done, werr
    );
    modport slave (
        input  rd_valid, rd_sel, wen, wsel, wdata, wmask, clear_req,
        output rd_ready, rd_data_valid, rd_data, busy, clear_done, werr
    );
endinterface

// File: rtl/veggie_banked_rf.sv
// veggie_banked_rf: multi-bank, multi-read-port vector register file with
// round-robin bank arbitration, write-to-read bypass and multi-cycle bulk clear.
module veggie_banked_rf #(
    parameter int NUM_REGS     = 32,
    parameter int NUM_BANKS    = 4,
    parameter int NUM_ELEMENTS = 16,
    parameter int ELEM_W       = 16,
    parameter int NUM_RPORTS   = 2
) (
    input logic CLK,
    input logic nRST,
    veggie_banked_rf_if.slave bus
);
    localparam int SW   = $clog2(NUM_REGS);
    localparam int BW   = $clog2(NUM_BANKS);
    localparam int ROWS = NUM_REGS / NUM_BANKS;
    localparam int RW   = SW - BW;
    localparam int PW   = NUM_RPORTS > 1 ? $clog2(NUM_RPORTS) : 1;

    typedef logic [NUM_ELEMENTS-1:0][ELEM_W-1:0] vec_t;
    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                state;
    vec_t                  mem [NUM_BANKS][ROWS];
    logic [PW-1:0]         ptr [NUM_BANKS];
    logic [PW-1:0]         win [NUM_BANKS];
    logic [NUM_BANKS-1:0]  found;
    logic [NUM_BANKS-1:0]  conflict;
    logic [RW-1:0]         row;
    logic [NUM_RPORTS-1:0] grant;
    vec_t                  rd_val [NUM_RPORTS];
    logic                  idle;

    assign idle         = state == IDLE;
    assign bus.rd_ready = grant;

    // Bank winner: first requester at or after the pointer, wrapping to the lowest requester.
    always_comb begin
        found = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            win[b] = ptr[b];
            for (int p = 0; p < NUM_RPORTS; p++)
                if (!found[b] && bus.rd_valid[p] && bus.rd_sel[p][BW-1:0] == BW'(b) && PW'(p) >= ptr[b]) begin
                    found[b] = 1'b1;
                    win[b]   = PW'(p);
                end
            for (int p = 0; p < NUM_RPORTS; p++)
                if (!found[b] && bus.rd_valid[p] && bus.rd_sel[p][BW-1:0] == BW'(b)) begin
                    found[b] = 1'b1;
                    win[b]   = PW'(p);
                end
        end
    end

    // Ports asking for the winner's register share the grant; any other register in that bank loses.
    always_comb begin
        grant    = '0;
        conflict = '0;
        for (int p = 0; p < NUM_RPORTS; p++)
            if (idle && bus.rd_valid[p]) begin
                if (bus.rd_sel[p] == bus.rd_sel[win[bus.rd_sel[p][BW-1:0]]])
                    grant[p] = 1'b1;
                else
                    conflict[bus.rd_sel[p][BW-1:0]] = 1'b1;
            end
    end

    always_comb
        for (int p = 0; p < NUM_RPORTS; p++) begin
            rd_val[p] = mem[bus.rd_sel[p][BW-1:0]][bus.rd_sel[p][SW-1:BW]];
            for (int e = 0; e < NUM_ELEMENTS; e++)
                rd_val[p][e] = (bus.wen && bus.wsel == bus.rd_sel[p] && bus.wmask[e]) ? bus.wdata[e] : rd_val[p][e];
        end

    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) begin
            state             <= IDLE;
            row               <= '0;
            bus.busy          <= 1'b0;
            bus.clear_done    <= 1'b0;
            bus.werr          <= 1'b0;
            bus.rd_data_valid <= '0;
            bus.rd_data       <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                ptr[b] <= '0;
                for (int r = 0; r < ROWS; r++)
                    mem[b][r] <= '0;
            end
        end else begin
            bus.rd_data_valid <= grant;
            for (int p = 0; p < NUM_RPORTS; p++)
                if (grant[p])
                    bus.rd_data[p] <= rd_val[p];
            for (int b = 0; b < NUM_BANKS; b++)
                ptr[b] <= conflict[b] ? (win[b] == PW'(NUM_RPORTS - 1) ? '0 : win[b] + 1'b1) : ptr[b];
            bus.clear_done <= 1'b0;
            bus.werr       <= 1'b0;
            if (state == CLEAR) begin
                for (int b = 0; b < NUM_BANKS; b++)
                    mem[b][row] <= '0;
                bus.werr <= bus.wen;
                row      <= row + 1'b1;
                if (&row) begin
                    state          <= IDLE;
                    bus.busy       <= 1'b0;
                    bus.clear_done <= 1'b1;
                end
            end else begin
                if (bus.wen)
                    for (int e = 0; e < NUM_ELEMENTS; e++)
                        if (bus.wmask[e])
                            mem[bus.wsel[BW-1:0]][bus.wsel[SW-1:BW]][e] <= bus.wdata[e];
                if (bus.clear_req) begin
                    state    <= CLEAR;
                    bus.busy <= 1'b1;
                    row      <= '0;
                end
            end
        end
endmodule

// File: tb/tb_veggie_banked_rf.sv
// tb_veggie_banked_rf: directed vector table, clear/reset sequences and
// randomized traffic checked against a register-array reference model.
module tb_veggie_banked_rf;
    localparam int NREG = 32;
    localparam int NB   = 4;
    localparam int NE   = 16;
    localparam int EW   = 16;
    localparam int NR   = 2;

    typedef logic [NE-1:0][EW-1:0] vec_t;

    typedef struct {
        logic [1:0]  v;
        logic [4:0]  s0, s1;
        logic        we;
        logic [4:0]  ws;
        logic [15:0] wd, wm;
        logic [1:0]  rdy, rdv;
        logic [15:0] p0e0, p0e15, p1e0, p1e15;
    } rec_t;

    logic clk, nRST;
    veggie_banked_rf_if #(.NUM_REGS(NREG), .NUM_ELEMENTS(NE), .ELEM_W(EW), .NUM_RPORTS(NR)) bus();
    veggie_banked_rf #(.NUM_REGS(NREG), .NUM_BANKS(NB), .NUM_ELEMENTS(NE), .ELEM_W(EW), .NUM_RPORTS(NR))
        dut (.CLK(clk), .nRST(nRST), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    vec_t          m [NREG];
    int            ptr_m [NB];
    bit            clearing;
    int            row_m;
    vec_t          exp_rd [NR];
    logic [NR-1:0] exp_rdv, seen_ready;
    logic          exp_cd, exp_werr;
    rec_t          tbl [11];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) m[r] = '0;
        for (int b = 0; b < NB; b++) ptr_m[b] = 0;
        for (int p = 0; p < NR; p++) exp_rd[p] = '0;
        clearing = 0;
        row_m    = 0;
        exp_rdv  = '0;
        exp_cd   = 0;
        exp_werr = 0;
    endtask

    function automatic vec_t merge(input vec_t old);
        for (int e = 0; e < NE; e++)
            if (bus.wmask[e]) old[e] = bus.wdata[e];
        return old;
    endfunction

    task automatic check_outputs();
        check("rd_data_valid", bus.rd_data_valid, exp_rdv);
        for (int p = 0; p < NR; p++)
            check($sformatf("rd_data%0d", p), bus.rd_data[p], exp_rd[p]);
        check("busy", bus.busy, clearing);
        check("clear_done", bus.clear_done, exp_cd);
        check("werr", bus.werr, exp_werr);
    endtask

    // One clock: predict grants from the current requests, check them, advance the model.
    task automatic step();
        int            sel [NR];
        int            win [NB];
        logic [NR-1:0] g;
        logic [NB-1:0] conf;
        int            q;
        vec_t          v;
        @(negedge clk);
        for (int p = 0; p < NR; p++) sel[p] = int'(bus.rd_sel[p]);
        g    = '0;
        conf = '0;
        for (int b = 0; b < NB; b++) begin
            win[b] = -1;
            for (int k = 0; k < NR; k++) begin
                q = (ptr_m[b] + k) % NR;
                if (win[b] < 0 && bus.rd_valid[q] && sel[q] % NB == b) win[b] = q;
            end
        end
        if (!clearing)
            for (int p = 0; p < NR; p++)
                if (bus.rd_valid[p]) begin
                    if (sel[p] == sel[win[sel[p] % NB]]) g[p] = 1'b1;
                    else conf[sel[p] % NB] = 1'b1;
                end
        seen_ready = bus.rd_ready;
        check("rd_ready", bus.rd_ready, g);
        for (int p = 0; p < NR; p++)
            if (g[p]) begin
                v = m[sel[p]];
                if (bus.wen && int'(bus.wsel) == sel[p]) v = merge(v);
                exp_rd[p] = v;
            end
        exp_rdv = g;
        for (int b = 0; b < NB; b++)
            if (conf[b]) ptr_m[b] = (win[b] + 1) % NR;
        exp_werr = clearing && bus.wen;
        exp_cd   = 0;
        if (clearing) begin
            for (int b = 0; b < NB; b++) m[row_m * NB + b] = '0;
            row_m++;
            if (row_m == NREG / NB) begin
                clearing = 0;
                exp_cd   = 1;
            end
        end else begin
            if (bus.wen) m[bus.wsel] = merge(m[bus.wsel]);
            if (bus.clear_req) begin
                clearing = 1;
                row_m    = 0;
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        bus.rd_valid  = '0;
        bus.rd_sel    = '0;
        bus.wen       = 0;
        bus.wsel      = '0;
        bus.wdata     = '0;
        bus.wmask     = '0;
        bus.clear_req = 0;
    endtask

    task automatic fill_random(input int first, input int last);
        bus.rd_valid = '0;
        for (int r = first; r <= last; r++) begin
            bus.wen   = 1;
            bus.wsel  = 5'(r);
            bus.wmask = 16'hFFFF;
            for (int e = 0; e < NE; e++) bus.wdata[e] = 16'($urandom) | 16'h1;
            step();
        end
        bus.wen = 0;
    endtask

    task automatic read_all();
        bus.wen      = 0;
        bus.rd_valid = 2'b11;
        for (int r = 0; r < NREG; r++) begin
            bus.rd_sel[0] = 5'(r);
            bus.rd_sel[1] = 5'(NREG - 1 - r);
            step();
        end
        bus.rd_valid = '0;
    endtask

    initial begin
        int busy_cnt, done_cnt, werr_cnt;
        tbl[0]  = '{2'b01, 5'd5, 5'd0, 1'b0, 5'd0, 16'h0000, 16'h0000, 2'b01, 2'b01, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        tbl[1]  = '{2'b10, 5'd0, 5'd3, 1'b1, 5'd3, 16'h3C00, 16'h00FF, 2'b10, 2'b10, 16'h0000, 16'h0000, 16'h3C00, 16'h0000};
        tbl[2]  = '{2'b10, 5'd0, 5'd3, 1'b0, 5'd0, 16'h0000, 16'h0000, 2'b10, 2'b10, 16'h0000, 16'h0000, 16'h3C00, 16'h0000};
        tbl[3]  = '{2'b00, 5'd0, 5'd0, 1'b1, 5'd1, 16'h1111, 16'hFFFF, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h3C00, 16'h0000};
        tbl[4]  = '{2'b00, 5'd0, 5'd0, 1'b1, 5'd5, 16'h5555, 16'hFFFF, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h3C00, 16'h0000};
        tbl[5]  = '{2'b11, 5'd1, 5'd5, 1'b0, 5'd0, 16'h0000, 16'h0000, 2'b01, 2'b01, 16'h1111, 16'h1111, 16'h3C00, 16'h0000};
        tbl[6]  = '{2'b11, 5'd1, 5'd5, 1'b0, 5'd0, 16'h0000, 16'h0000, 2'b10, 2'b10, 16'h1111, 16'h1111, 16'h5555, 16'h5555};
        tbl[7]  = '{2'b11, 5'd1, 5'd5, 1'b0, 5'd0, 16'h0000, 16'h0000, 2'b01, 2'b01, 16'h1111, 16'h1111, 16'h5555, 16'h5555};
        tbl[8]  = '{2'b00, 5'd0, 5'd0, 1'b1, 5'd7, 16'h7777, 16'hFFFF, 2'b00, 2'b00, 16'h1111, 16'h1111, 16'h5555, 16'h5555};
        tbl[9]  = '{2'b11, 5'd7, 5'd7, 1'b0, 5'd0, 16'h0000, 16'h0000, 2'b11, 2'b11, 16'h7777, 16'h7777, 16'h7777, 16'h7777};
        tbl[10] = '{2'b11, 5'd3, 5'd7, 1'b0, 5'd0, 16'h0000, 16'h0000, 2'b01, 2'b01, 16'h3C00, 16'h0000, 16'h7777, 16'h7777};

        nRST = 0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        nRST = 1;

        for (int i = 0; i < 11; i++) begin
            bus.rd_valid  = tbl[i].v;
            bus.rd_sel[0] = tbl[i].s0;
            bus.rd_sel[1] = tbl[i].s1;
            bus.wen       = tbl[i].we;
            bus.wsel      = tbl[i].ws;
            bus.wmask     = tbl[i].wm;
            for (int e = 0; e < NE; e++) bus.wdata[e] = tbl[i].wd;
            step();
            check($sformatf("t%0d rd_ready", i), seen_ready, tbl[i].rdy);
            check($sformatf("t%0d rd_data_valid", i), bus.rd_data_valid, tbl[i].rdv);
            check($sformatf("t%0d p0e0", i), bus.rd_data[0][0], tbl[i].p0e0);
            check($sformatf("t%0d p0e15", i), bus.rd_data[0][15], tbl[i].p0e15);
            check($sformatf("t%0d p1e0", i), bus.rd_data[1][0], tbl[i].p1e0);
            check($sformatf("t%0d p1e15", i), bus.rd_data[1][15], tbl[i].p1e15);
        end
        idle_inputs();

        fill_random(0, NREG - 1);
        bus.clear_req = 1;
        bus.rd_valid  = 2'b11;
        bus.rd_sel[0] = 5'd2;
        bus.rd_sel[1] = 5'd9;
        step();
        bus.clear_req = 0;
        busy_cnt = int'(bus.busy);
        done_cnt = 0;
        werr_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            bus.wen       = (i == 3);
            bus.wsel      = 5'd4;
            bus.wmask     = 16'hFFFF;
            bus.wdata     = '1;
            bus.clear_req = (i == 5);
            step();
            busy_cnt += int'(bus.busy);
            done_cnt += int'(bus.clear_done);
            werr_cnt += int'(bus.werr);
        end
        check("clear busy cycles", 256'(busy_cnt), 256'(8));
        check("clear_done pulses", 256'(done_cnt), 256'(1));
        check("werr pulses", 256'(werr_cnt), 256'(1));
        idle_inputs();
        read_all();

        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < NR; p++)
                if (!(bus.rd_valid[p] && !seen_ready[p])) begin
                    bus.rd_valid[p] = 1'($urandom_range(0, 1));
                    bus.rd_sel[p]   = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
                end
            bus.wen       = 1'($urandom_range(0, 1));
            bus.wsel      = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            bus.wmask     = 16'($urandom);
            bus.clear_req = ($urandom_range(0, 49) == 0);
            for (int e = 0; e < NE; e++) bus.wdata[e] = 16'($urandom);
            step();
        end
        idle_inputs();
        repeat (10) step();

        fill_random(0, 15);
        bus.clear_req = 1;
        step();
        bus.clear_req = 0;
        repeat (3) step();
        check("busy before reset", bus.busy, 1'b1);
        #2;
        nRST = 0;
        #1;
        model_reset();
        check_outputs();
        repeat (2) @(posedge clk);
        #1;
        nRST = 1;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            done_cnt += int'(bus.clear_done);
        end
        check("clear_done after reset", 256'(done_cnt), 256'(0));
        read_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
